// File: rtl/e_muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers (MIPS E stage).
// Optional madd/maddu accumulate ops are enabled by defining MULDIV_MADD_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no operation in flight; accepts mult/div/mthi/mtlo
// ST_BUSY | result held in pending regs, counting down to commit
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_Start,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    localparam logic [4:0] LP_MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] LP_DIV_CNT  = 5'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_pend;
    logic        r_pend_valid;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_madd;
    logic        w_launch;
    logic        w_signed_op;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic [63:0] w_result;

    assign w_accept = E_Start && (r_state == ST_IDLE);
    assign w_is_mul = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU);
    assign w_is_div = (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);

`ifdef MULDIV_MADD_EN
    assign w_is_madd = (E_MDOp == OP_MADD) || (E_MDOp == OP_MADDU);
`else
    assign w_is_madd = 1'b0;
`endif

    assign w_launch    = w_accept && (w_is_mul || w_is_div || w_is_madd);
    assign w_signed_op = (E_MDOp == OP_MULT) || (E_MDOp == OP_DIV) || (E_MDOp == OP_MADD);

    // Low 64 bits of a product of sign-extended operands equal the signed 64-bit product.
    assign w_prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};
    assign w_prod   = w_signed_op ? w_prod_s : w_prod_u;

    // Signed division done on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_a_neg    = w_signed_op && E_A[31];
    assign w_b_neg    = w_signed_op && E_B[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - E_A) : E_A;
    assign w_b_mag    = w_b_neg ? (32'd0 - E_B) : E_B;
    assign w_div_zero = (E_B == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_result = 64'd0;
        if (w_is_mul) begin
            w_result = w_prod;
        end else if (w_is_div) begin
            w_result = {w_rem, w_quot};
        end
`ifdef MULDIV_MADD_EN
        else if (w_is_madd) begin
            w_result = {r_hi, r_lo} + w_prod;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 5'd0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_pend       <= 64'd0;
            r_pend_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_pend       <= w_result;
                        r_pend_valid <= !(w_is_div && w_div_zero);
                        r_cnt        <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
                        r_state      <= ST_BUSY;
                    end else if (w_accept && (E_MDOp == OP_MTHI)) begin
                        r_hi <= E_A;
                    end else if (w_accept && (E_MDOp == OP_MTLO)) begin
                        r_lo <= E_A;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt <= 5'd1) begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= 5'd0;
                        r_pend_valid <= 1'b0;
                        if (r_pend_valid) begin
                            r_hi <= r_pend[63:32];
                            r_lo <= r_pend[31:0];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

    assign E_Busy = (r_state == ST_BUSY);
    assign E_HI   = r_hi;
    assign E_LO   = r_lo;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed vector table, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_e_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_Start;
    logic [3:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .E_Start(E_Start),
        .E_MDOp (E_MDOp),
        .E_A    (E_A),
        .E_B    (E_B),
        .E_Busy (E_Busy),
        .E_HI   (E_HI),
        .E_LO   (E_LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, then count busy cycles; returns at the first negedge with Busy low.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy);
        @(negedge clk);
        E_Start = 1'b1; E_MDOp = op; E_A = a; E_B = b;
        @(negedge clk);
        E_Start = 1'b0; E_MDOp = 4'd0;
        busy = 0;
        while (E_Busy === 1'b1 && busy < 64) begin
            busy++;
            @(negedge clk);
        end
    endtask

    // Reference: architectural effect of one op on {m_hi, m_lo} and its busy length.
    task automatic ref_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        longint      sa, sb, ua, ub, q, r;
        logic [63:0] v;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        lat = 0;
        case (op)
            4'd1: begin v = sa * sb; {m_hi, m_lo} = v; lat = MC; end
            4'd2: begin v = ua * ub; {m_hi, m_lo} = v; lat = MC; end
            4'd3: begin
                lat = DC;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    v = q; m_lo = v[31:0];
                    v = r; m_hi = v[31:0];
                end
            end
            4'd4: begin
                lat = DC;
                if (b != 0) begin
                    q = ua / ub; r = ua % ub;
                    v = q; m_lo = v[31:0];
                    v = r; m_hi = v[31:0];
                end
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MULDIV_MADD_EN
            4'd7: begin v = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + v; lat = MC; end
            4'd8: begin v = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + v; lat = MC; end
`endif
            default: lat = 0;
        endcase
    endtask

    initial begin
        int busy;
        int lat;
        int bad;
        logic [3:0]  op;
        logic [31:0] a, b;

        vt[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,          MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vt[1]  = '{4'd2, 32'hFFFF_FFFE, 32'd3,          MC, 32'h0000_0002, 32'hFFFF_FFFA};
        vt[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,          DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3]  = '{4'd4, 32'd7,         32'd2,          DC, 32'd1,         32'd3};
        vt[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  DC, 32'd0,         32'h8000_0000};
        vt[5]  = '{4'd5, 32'h0000_1234, 32'd0,          0,  32'h0000_1234, 32'h8000_0000};
        vt[6]  = '{4'd6, 32'h0000_5678, 32'd0,          0,  32'h0000_1234, 32'h0000_5678};
        vt[7]  = '{4'd3, 32'd9,         32'd0,          DC, 32'h0000_1234, 32'h0000_5678};
        vt[8]  = '{4'd0, 32'hDEAD_BEEF, 32'd5,          0,  32'h0000_1234, 32'h0000_5678};
        vt[9]  = '{4'd12, 32'hCAFE_F00D, 32'd7,         0,  32'h0000_1234, 32'h0000_5678};
        vt[10] = '{4'd5, 32'd0,         32'd0,          0,  32'd0,         32'h0000_5678};
        vt[11] = '{4'd6, 32'hFFFF_FFFF, 32'd0,          0,  32'd0,         32'hFFFF_FFFF};
`ifdef MULDIV_MADD_EN
        vt[12] = '{4'd8, 32'd1,         32'd1,          MC, 32'd1,         32'd0};
`else
        vt[12] = '{4'd8, 32'd1,         32'd1,          0,  32'd0,         32'hFFFF_FFFF};
`endif

        reset = 1'b1; E_Start = 1'b0; E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(E_Busy), 64'd0);
        chk("reset_hi", 64'(E_HI), 64'd0);
        chk("reset_lo", 64'(E_LO), 64'd0);

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, busy);
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].busy));
            chk($sformatf("vec%0d_hi", i), 64'(E_HI), 64'(vt[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(E_LO), 64'(vt[i].lo));
        end

        // Reset in the third busy cycle aborts the mult with no later commit.
        @(negedge clk);
        E_Start = 1'b1; E_MDOp = 4'd1; E_A = 32'd3; E_B = 32'd4;
        @(negedge clk);
        E_Start = 1'b0; E_MDOp = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy_before", 64'(E_Busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 64'(E_Busy), 64'd0);
        chk("rst_mid_hi", 64'(E_HI), 64'd0);
        chk("rst_mid_lo", 64'(E_LO), 64'd0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) bad++;
        end
        chk("rst_mid_no_commit", 64'(bad), 64'd0);

        // Reset and Start in the same cycle: reset wins.
        E_Start = 1'b1; E_MDOp = 4'd6; E_A = 32'h5555_5555; reset = 1'b1;
        @(negedge clk);
        E_Start = 1'b0; E_MDOp = 4'd0; reset = 1'b0;
        chk("rst_start_busy", 64'(E_Busy), 64'd0);
        chk("rst_start_lo", 64'(E_LO), 64'd0);

        // Starts while busy, including on the completion edge, are ignored.
        E_Start = 1'b1; E_MDOp = 4'd1; E_A = 32'd2; E_B = 32'd2;
        @(negedge clk);
        chk("busy_ign_c1", 64'(E_Busy), 64'd1);
        E_MDOp = 4'd5; E_A = 32'h0000_AAAA;
        @(negedge clk);
        E_MDOp = 4'd1; E_A = 32'd5; E_B = 32'd5;
        @(negedge clk);
        E_Start = 1'b0; E_MDOp = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_ign_c5", 64'(E_Busy), 64'd1);
        E_Start = 1'b1; E_MDOp = 4'd6; E_A = 32'h0000_BBBB;
        @(negedge clk);
        E_Start = 1'b0; E_MDOp = 4'd0;
        chk("busy_ign_done", 64'(E_Busy), 64'd0);
        chk("busy_ign_hi", 64'(E_HI), 64'd0);
        chk("busy_ign_lo", 64'(E_LO), 64'd4);
        @(negedge clk);
        chk("busy_ign_lo_after", 64'(E_LO), 64'd4);
        chk("busy_ign_idle_after", 64'(E_Busy), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd4;

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 15))
                0, 1: b = 32'd0;
                2:    b = 32'hFFFF_FFFF;
                3:    begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:    b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, a, b, busy);
            ref_step(op, a, b, lat);
            chk($sformatf("rnd%0d_op%0d_busy", i, op), 64'(busy), 64'(lat));
            chk($sformatf("rnd%0d_op%0d_hi", i, op), 64'(E_HI), 64'(m_hi));
            chk($sformatf("rnd%0d_op%0d_lo", i, op), 64'(E_LO), 64'(m_lo));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
